av_mailbox_slave: RTL and testbench

- Avalon-MM slave (responder) with waitrequest handshake, 16-bit data; the counterpart to the MCU's register-driven Avalon master inside the qsys2 system.
- Exposes two FIFOs to the Avalon side:
  - RX: local peripheral → Avalon read.
  - TX: Avalon write → local peripheral.
- Also exposes status, control and scratch registers, plus a level interrupt.
- Lets the MCU exchange word streams with fabric logic through the existing DR_AV_* register path.

---
 rtl/av_mailbox_pkg.sv | 37 +++
 rtl/mbox_fifo.sv | 76 +++++++
 rtl/av_mailbox_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_av_mailbox_slave.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/av_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : av_mailbox_pkg
// Description : Shared constants and types for the Avalon-MM mailbox slave.
//               Holds the register map addresses, the STATUS/CTRL bit
//               positions and the transaction FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package av_mailbox_pkg;

    // Word addresses on the Avalon side
    localparam logic [2:0] c_ADDR_STATUS  = 3'd0;
    localparam logic [2:0] c_ADDR_RX_DATA = 3'd1;
    localparam logic [2:0] c_ADDR_TX_DATA = 3'd2;
    localparam logic [2:0] c_ADDR_SCRATCH = 3'd3;
    localparam logic [2:0] c_ADDR_CTRL    = 3'd4;

    // STATUS layout: [4:0] rx_count, [9:5] tx_count, then flag bits
    localparam int c_ST_RX_NONEMPTY  = 10;
    localparam int c_ST_TX_FULL      = 11;
    localparam int c_ST_RD_UNDERFLOW = 12;
    localparam int c_ST_TX_DROP      = 13;

    // CTRL layout: bit0 is a real register, bits 1..3 are write-1 pulses
    localparam int c_CTRL_IRQ_EN    = 0;
    localparam int c_CTRL_RX_FLUSH  = 1;
    localparam int c_CTRL_TX_FLUSH  = 2;
    localparam int c_CTRL_CLR_STICKY = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WSTALL = 2'd1,
        S_ACK    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mbox_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mbox_fifo
// Description : Synchronous single-clock FIFO with occupancy count and a
//               combinational head output. Flush has priority over push/pop.
// Ports       : clk, rst_n (async active-low)
//               i_push/i_data  - write side (ignored when full)
//               i_pop          - read side (ignored when empty)
//               i_flush        - empties the FIFO on the next edge
//               o_full, o_empty, o_count (0..DEPTH), o_head
// Revision    : 1.0 - initial release
// ============================================================================
module mbox_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // DEPTH is a power of two, so pointers wrap naturally at AW bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/av_mailbox_slave.sv
`default_nettype none
// ============================================================================
// Module      : av_mailbox_slave
// Description : Avalon-MM slave mailbox with waitrequest handshake. An RX
//               FIFO carries words from local logic to Avalon reads, a TX
//               FIFO carries Avalon writes to local logic. Also provides
//               STATUS, CTRL and SCRATCH registers and a level interrupt.
// Ports       : sysclk, sysreset_n (async active-low)
//               av_*           - Avalon-MM slave interface, 3-bit word address
//               rx_in_*        - local valid/ready push into RX FIFO
//               tx_out_*       - local valid/ready pop from TX FIFO
//               irq            - registered level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module av_mailbox_slave
    import av_mailbox_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int STALL_MAX = 64
) (
    input  logic        sysclk,
    input  logic        sysreset_n,
    input  logic [2:0]  av_address,
    input  logic        av_read,
    input  logic        av_write,
    input  logic [15:0] av_writedata,
    output logic [15:0] av_readdata,
    output logic        av_waitrequest,
    input  logic [15:0] rx_in_data,
    input  logic        rx_in_valid,
    output logic        rx_in_ready,
    output logic [15:0] tx_out_data,
    output logic        tx_out_valid,
    input  logic        tx_out_ready,
    output logic        irq
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int SCW = $clog2(STALL_MAX + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SCW-1:0]  r_stall_cnt;
    logic [SCW-1:0]  w_stall_cnt_nxt;
    logic [15:0]     r_readdata;
    logic [15:0]     r_scratch;
    logic            r_irq_en;
    logic            r_underflow;
    logic            r_drop;
    logic            r_irq;
    logic            r_run;

    logic            w_tx_push;
    logic            w_rx_pop;
    logic            w_rx_push;
    logic            w_rd_capture;
    logic            w_set_underflow;
    logic            w_set_drop;
    logic            w_scratch_we;
    logic            w_ctrl_we;
    logic            w_rx_flush;
    logic            w_tx_flush;
    logic            w_clr_sticky;
    logic [15:0]     w_rdata;
    logic [15:0]     w_status;

    logic            w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic [CW-1:0]   w_rx_count, w_tx_count;
    logic [15:0]     w_rx_head, w_tx_head;

    // ---------------------------------------------------------------- FIFOs
    mbox_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_rx_fifo (
        .clk     (sysclk),
        .rst_n   (sysreset_n),
        .i_push  (w_rx_push),
        .i_data  (rx_in_data),
        .i_pop   (w_rx_pop),
        .i_flush (w_rx_flush),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count),
        .o_head  (w_rx_head)
    );

    mbox_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_tx_fifo (
        .clk     (sysclk),
        .rst_n   (sysreset_n),
        .i_push  (w_tx_push),
        .i_data  (av_writedata),
        .i_pop   (tx_out_valid & tx_out_ready),
        .i_flush (w_tx_flush),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count),
        .o_head  (w_tx_head)
    );

    // r_run holds rx_in_ready low while reset is asserted; a pending flush
    // also refuses the push so the flushed FIFO is really empty afterwards.
    assign rx_in_ready    = r_run & ~w_rx_full & ~w_rx_flush;
    assign w_rx_push      = rx_in_valid & rx_in_ready;
    assign tx_out_data    = w_tx_head;
    assign tx_out_valid   = ~w_tx_empty;
    assign av_waitrequest = (r_state != S_ACK);
    assign av_readdata    = r_readdata;
    assign irq            = r_irq;

    assign w_rx_flush   = w_ctrl_we & av_writedata[c_CTRL_RX_FLUSH];
    assign w_tx_flush   = w_ctrl_we & av_writedata[c_CTRL_TX_FLUSH];
    assign w_clr_sticky = w_ctrl_we & av_writedata[c_CTRL_CLR_STICKY];

    // ------------------------------------------------------------ read mux
    assign w_status = {2'b00, r_drop, r_underflow, w_tx_full, ~w_rx_empty,
                       5'(w_tx_count), 5'(w_rx_count)};

    always_comb begin
        w_rdata = '0;
        if (av_address == c_ADDR_STATUS) begin
            w_rdata = w_status;
        end else if (av_address == c_ADDR_RX_DATA) begin
            w_rdata = w_rx_empty ? 16'h0000 : w_rx_head;
        end else if (av_address == c_ADDR_SCRATCH) begin
            w_rdata = r_scratch;
        end else if (av_address == c_ADDR_CTRL) begin
            w_rdata = {15'd0, r_irq_en};
        end
    end

    // ------------------------------------------------------------ FSM comb
    always_comb begin
        w_state_nxt     = r_state;
        w_stall_cnt_nxt = r_stall_cnt;
        w_tx_push       = 1'b0;
        w_rx_pop        = 1'b0;
        w_rd_capture    = 1'b0;
        w_set_underflow = 1'b0;
        w_set_drop      = 1'b0;
        w_scratch_we    = 1'b0;
        w_ctrl_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Write wins when both strobes are high
                if (av_write) begin
                    if (av_address == c_ADDR_TX_DATA) begin
                        if (!w_tx_full) begin
                            w_tx_push   = 1'b1;
                            w_state_nxt = S_ACK;
                        end else begin
                            w_stall_cnt_nxt = '0;
                            w_state_nxt     = S_WSTALL;
                        end
                    end else begin
                        w_scratch_we = (av_address == c_ADDR_SCRATCH);
                        w_ctrl_we    = (av_address == c_ADDR_CTRL);
                        w_state_nxt  = S_ACK;
                    end
                end else if (av_read) begin
                    w_rd_capture = 1'b1;
                    if (av_address == c_ADDR_RX_DATA) begin
                        if (w_rx_empty) begin
                            w_set_underflow = 1'b1;
                        end else begin
                            w_rx_pop = 1'b1;
                        end
                    end
                    w_state_nxt = S_ACK;
                end
            end
            S_WSTALL: begin
                // Master holds av_writedata stable while waitrequest is high
                if (!w_tx_full) begin
                    w_tx_push   = 1'b1;
                    w_state_nxt = S_ACK;
                end else if (r_stall_cnt == SCW'(STALL_MAX - 1)) begin
                    w_set_drop  = 1'b1;
                    w_state_nxt = S_ACK;
                end else begin
                    w_stall_cnt_nxt = r_stall_cnt + SCW'(1);
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            r_state     <= S_IDLE;
            r_stall_cnt <= '0;
            r_readdata  <= '0;
            r_scratch   <= '0;
            r_irq_en    <= 1'b0;
            r_underflow <= 1'b0;
            r_drop      <= 1'b0;
            r_irq       <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_run       <= 1'b1;
            if (w_rd_capture) begin
                r_readdata <= w_rdata;
            end
            if (w_scratch_we) begin
                r_scratch <= av_writedata;
            end
            if (w_ctrl_we) begin
                r_irq_en <= av_writedata[c_CTRL_IRQ_EN];
            end
            // A set event in the same cycle as a clear takes effect
            r_underflow <= w_set_underflow | (r_underflow & ~w_clr_sticky);
            r_drop      <= w_set_drop | (r_drop & ~w_clr_sticky);
            r_irq       <= r_irq_en & (~w_rx_empty | r_underflow | r_drop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_av_mailbox_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_av_mailbox_slave
// Description : Directed self-checking bench for av_mailbox_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_av_mailbox_slave;

    localparam int DEPTH     = 8;
    localparam int STALL_MAX = 64;
    localparam int BUDGET    = 200;

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_RX_DATA = 3'd1;
    localparam logic [2:0] A_TX_DATA = 3'd2;
    localparam logic [2:0] A_SCRATCH = 3'd3;
    localparam logic [2:0] A_CTRL    = 3'd4;

    logic        sysclk       = 1'b0;
    logic        sysreset_n   = 1'b0;
    logic [2:0]  av_address   = '0;
    logic        av_read      = 1'b0;
    logic        av_write     = 1'b0;
    logic [15:0] av_writedata = '0;
    logic [15:0] av_readdata;
    logic        av_waitrequest;
    logic [15:0] rx_in_data   = '0;
    logic        rx_in_valid  = 1'b0;
    logic        rx_in_ready;
    logic [15:0] tx_out_data;
    logic        tx_out_valid;
    logic        tx_out_ready = 1'b0;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 sysclk = ~sysclk;

    av_mailbox_slave #(.DEPTH(DEPTH), .STALL_MAX(STALL_MAX)) dut (
        .sysclk         (sysclk),
        .sysreset_n     (sysreset_n),
        .av_address     (av_address),
        .av_read        (av_read),
        .av_write       (av_write),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .rx_in_data     (rx_in_data),
        .rx_in_valid    (rx_in_valid),
        .rx_in_ready    (rx_in_ready),
        .tx_out_data    (tx_out_data),
        .tx_out_valid   (tx_out_valid),
        .tx_out_ready   (tx_out_ready),
        .irq            (irq)
    );

    // Bus write, started on a falling edge; n = cycles with waitrequest high
    task automatic av_wr(input logic [2:0] a, input logic [15:0] d, output int n);
        av_address = a; av_writedata = d; av_write = 1'b1; n = 0;
        while (av_waitrequest && n < BUDGET) begin n++; @(negedge sysclk); end
        checks++;
        if (av_waitrequest !== 1'b0) begin
            errors++; $display("FAIL wr_timeout: waitrequest=%b required 0 within %0d cycles", av_waitrequest, BUDGET);
        end
        av_write = 1'b0;
        @(negedge sysclk);
        checks++;
        if (av_waitrequest !== 1'b1) begin
            errors++; $display("FAIL wr_ack_len: waitrequest=%b required 1 after one ack cycle", av_waitrequest);
        end
    endtask

    task automatic av_rd(input logic [2:0] a, output logic [15:0] d, output int n);
        av_address = a; av_read = 1'b1; n = 0;
        while (av_waitrequest && n < BUDGET) begin n++; @(negedge sysclk); end
        checks++;
        if (av_waitrequest !== 1'b0) begin
            errors++; $display("FAIL rd_timeout: waitrequest=%b required 0 within %0d cycles", av_waitrequest, BUDGET);
        end
        d = av_readdata;
        av_read = 1'b0;
        @(negedge sysclk);
        checks++;
        if (av_waitrequest !== 1'b1) begin
            errors++; $display("FAIL rd_ack_len: waitrequest=%b required 1 after one ack cycle", av_waitrequest);
        end
    endtask

    task automatic test_reset();
        sysreset_n = 1'b0;
        repeat (2) @(negedge sysclk);
        checks++; if (av_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait: got %b expected 1", av_waitrequest); end
        checks++; if (av_readdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata: got %h expected 0000", av_readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
        checks++; if (rx_in_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready: got %b expected 0", rx_in_ready); end
        checks++; if (tx_out_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b expected 0", tx_out_valid); end
        sysreset_n = 1'b1;
        @(negedge sysclk);
        checks++; if (rx_in_ready !== 1'b1) begin errors++; $display("FAIL run_rx_ready: got %b expected 1", rx_in_ready); end
    endtask

    task automatic test_scratch();
        int n; logic [15:0] d;
        av_wr(A_SCRATCH, 16'h1234, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL scratch_wr_wait: got %0d expected 1", n); end
        av_rd(A_SCRATCH, d, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL scratch_rd_wait: got %0d expected 1", n); end
        checks++; if (d !== 16'h1234) begin errors++; $display("FAIL scratch_rd: got %h expected 1234", d); end
        av_rd(A_STATUS, d, n);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL status_idle: got %h expected 0000", d); end
    endtask

    task automatic test_rx();
        int n; logic [15:0] d; logic [15:0] exp_w;
        for (int i = 0; i < 3; i++) begin
            rx_in_data = 16'h00A1 + 16'(i); rx_in_valid = 1'b1;
            @(negedge sysclk);
        end
        rx_in_valid = 1'b0;
        av_rd(A_STATUS, d, n);
        checks++; if (d !== 16'h0403) begin errors++; $display("FAIL rx_status3: got %h expected 0403", d); end
        for (int i = 0; i < 3; i++) begin
            exp_w = 16'h00A1 + 16'(i);
            av_rd(A_RX_DATA, d, n);
            checks++; if (d !== exp_w) begin errors++; $display("FAIL rx_data%0d: got %h expected %h", i, d, exp_w); end
        end
        av_rd(A_RX_DATA, d, n);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rx_underflow_data: got %h expected 0000", d); end
        av_rd(A_STATUS, d, n);
        checks++; if (d !== 16'h1000) begin errors++; $display("FAIL rx_underflow_status: got %h expected 1000", d); end
        av_wr(A_CTRL, 16'h0008, n);
        av_rd(A_STATUS, d, n);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL clr_sticky: got %h expected 0000", d); end
    endtask

    task automatic test_rx_full();
        int n; logic [15:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            rx_in_data = 16'h0D00 + 16'(i); rx_in_valid = 1'b1;
            @(negedge sysclk);
        end
        rx_in_valid = 1'b0;
        checks++; if (rx_in_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b expected 0", rx_in_ready); end
        av_rd(A_STATUS, d, n);
        checks++; if (d !== 16'h0408) begin errors++; $display("FAIL rx_full_status: got %h expected 0408", d); end
        av_wr(A_CTRL, 16'h0002, n);
        av_rd(A_STATUS, d, n);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rx_flush: got %h expected 0000", d); end
    endtask

    task automatic test_tx_stall_release();
        int n; int k; logic [15:0] d; logic [15:0] exp_w;
        tx_out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) av_wr(A_TX_DATA, 16'h00B0 + 16'(i), n);
        av_rd(A_STATUS, d, n);
        checks++; if (d !== 16'h0900) begin errors++; $display("FAIL tx_full_status: got %h expected 0900", d); end
        k = 0;
        fork
            av_wr(A_TX_DATA, 16'h00B8, n);
            begin
                repeat (10) @(negedge sysclk);
                tx_out_ready = 1'b1;
                for (int c = 0; c < 40 && k < DEPTH + 1; c++) begin
                    if (tx_out_valid) begin
                        exp_w = 16'h00B0 + 16'(k);
                        checks++; if (tx_out_data !== exp_w) begin errors++; $display("FAIL tx_drain%0d: got %h expected %h", k, tx_out_data, exp_w); end
                        k++;
                    end
                    @(negedge sysclk);
                end
            end
        join
        tx_out_ready = 1'b0;
        checks++; if (n !== 12) begin errors++; $display("FAIL tx_stall_wait: got %0d expected 12", n); end
        checks++; if (k !== DEPTH + 1) begin errors++; $display("FAIL tx_drain_count: got %0d expected %0d", k, DEPTH + 1); end
        av_rd(A_STATUS, d, n);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL tx_no_drop: got %h expected 0000", d); end
    endtask

    task automatic test_tx_drop();
        int n; logic [15:0] d;
        tx_out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) av_wr(A_TX_DATA, 16'h00C0 + 16'(i), n);
        av_wr(A_TX_DATA, 16'h00C8, n);
        checks++; if (n !== STALL_MAX + 1) begin errors++; $display("FAIL tx_drop_wait: got %0d expected %0d", n, STALL_MAX + 1); end
        av_rd(A_STATUS, d, n);
        checks++; if (d !== 16'h2900) begin errors++; $display("FAIL tx_drop_status: got %h expected 2900", d); end
        checks++; if (tx_out_data !== 16'h00C0) begin errors++; $display("FAIL tx_head: got %h expected 00c0", tx_out_data); end
        av_wr(A_CTRL, 16'h000C, n);
        av_rd(A_STATUS, d, n);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL tx_flush_status: got %h expected 0000", d); end
        checks++; if (tx_out_valid !== 1'b0) begin errors++; $display("FAIL tx_flush_valid: got %b expected 0", tx_out_valid); end
    endtask

    task automatic test_irq();
        int n; logic [15:0] d;
        av_wr(A_CTRL, 16'h0001, n);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
        rx_in_data = 16'h0077; rx_in_valid = 1'b1;
        @(negedge sysclk);
        rx_in_valid = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b expected 0", irq); end
        @(negedge sysclk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq); end
        av_rd(A_RX_DATA, d, n);
        checks++; if (d !== 16'h0077) begin errors++; $display("FAIL irq_rx_data: got %h expected 0077", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b expected 0", irq); end
        av_rd(A_RX_DATA, d, n);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_sticky: got %b expected 1", irq); end
        av_wr(A_CTRL, 16'h0009, n);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
        av_rd(A_CTRL, d, n);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL ctrl_readback: got %h expected 0001", d); end
        av_wr(A_CTRL, 16'h0000, n);
    endtask

    task automatic test_reset_mid();
        int n; logic [15:0] d;
        tx_out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) av_wr(A_TX_DATA, 16'h00E0 + 16'(i), n);
        av_address = A_TX_DATA; av_writedata = 16'h00E8; av_write = 1'b1;
        repeat (5) @(negedge sysclk);
        checks++; if (av_waitrequest !== 1'b1) begin errors++; $display("FAIL wstall_wait: got %b expected 1", av_waitrequest); end
        av_write = 1'b0;
        #2 sysreset_n = 1'b0;
        #1;
        checks++; if (av_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_rst_wait: got %b expected 1", av_waitrequest); end
        checks++; if (tx_out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_tx_valid: got %b expected 0", tx_out_valid); end
        checks++; if (rx_in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_rx_ready: got %b expected 0", rx_in_ready); end
        @(negedge sysclk);
        sysreset_n = 1'b1;
        @(negedge sysclk);
        av_wr(A_SCRATCH, 16'h5A5A, n);
        av_address = A_SCRATCH; av_read = 1'b1;
        @(negedge sysclk);
        checks++; if (av_waitrequest !== 1'b0) begin errors++; $display("FAIL ack_wait: got %b expected 0", av_waitrequest); end
        checks++; if (av_readdata !== 16'h5A5A) begin errors++; $display("FAIL ack_rdata: got %h expected 5a5a", av_readdata); end
        av_read = 1'b0;
        #2 sysreset_n = 1'b0;
        #1;
        checks++; if (av_waitrequest !== 1'b1) begin errors++; $display("FAIL ack_rst_wait: got %b expected 1", av_waitrequest); end
        checks++; if (av_readdata !== 16'h0000) begin errors++; $display("FAIL ack_rst_rdata: got %h expected 0000", av_readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ack_rst_irq: got %b expected 0", irq); end
        @(negedge sysclk);
        sysreset_n = 1'b1;
        @(negedge sysclk);
        av_rd(A_SCRATCH, d, n);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL post_rst_scratch: got %h expected 0000", d); end
        av_rd(A_STATUS, d, n);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL post_rst_status: got %h expected 0000", d); end
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_rx();
        test_rx_full();
        test_tx_stall_release();
        test_tx_drop();
        test_irq();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
